instr_exec: RTL and testbench
=============================

# instr_exec

Execution stage of the PDP-8 pipeline, directly downstream of `instr_decode`. It accepts one decoded instruction at a time as `base_addr`, `pdp_mem_opcode` and `pdp_op7_opcode`, and runs any data-memory read/modify/write cycles. It then updates AC, Link and PC, and hands the next fetch address back to the decoder through `stall` and `PC_value`. It implements the memory-reference instructions and the OPR group 1 and group 2 microinstructions.

## Interface
- `START_ADDR`, default `12'o200`: PC value after reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `base_addr`  in  `ADDR_WIDTH`  effective operand address from the decoder.
- `pdp_mem_opcode`  in  `pdp_mem_opcode_s`  one-hot fields: AND, TAD, ISZ, DCA, JMS, JMP.
- `pdp_op7_opcode`  in  `pdp_op7_opcode_s`  flags: CLA, CLL, CMA, CML, IAC, RAR, RAL, RTR, RTL, BSW, SMA, SZA, SNL, SPA, SNA, SZL, HLT, OSR, NOP.
- `stall`  out  1  high while the stage is busy; the decoder holds its outputs and does not fetch.
- `PC_value`  out  `ADDR_WIDTH`  next instruction address; valid whenever `stall` is low.
- `exec_rd_req`  out  1  data read strobe, asserted for one cycle.
- `exec_rd_addr`  out  `ADDR_WIDTH`  read address.
- `exec_rd_data`  in  `DATA_WIDTH`  read data; valid exactly one cycle after `exec_rd_req`.
- `exec_wr_req`  out  1  write strobe, asserted for one cycle.
- `exec_wr_addr`  out  `ADDR_WIDTH`  write address.
- `exec_wr_data`  out  `DATA_WIDTH`  write data.

## Operation
- **State machine states:** IDLE, READ, WAIT, WRITE, RETIRE, HALTED.
- **Accept:** in IDLE, any set opcode field means an instruction is accepted. The stage captures `base_addr` and both opcodes, then moves to READ (AND/TAD/ISZ), WRITE (DCA/JMS) or RETIRE (JMP/op7). All-zero inputs mean no instruction: stay in IDLE.
- **READ:** `exec_rd_req`=1, `exec_rd_addr`=`base_addr`, then go to WAIT.
- **WAIT:** latch `exec_rd_data` into MB.
  - AND: AC &= MB.
  - TAD: {L,AC} = {L,AC} + MB, with carry-out complementing L.
  - ISZ: MB+1, then go to WRITE.
  - AND/TAD then go to RETIRE.
- **WRITE:** `exec_wr_req`=1 at `base_addr`.
  - DCA: writes AC, then AC cleared.
  - ISZ: writes MB+1 mod 4096.
  - JMS: writes PC+1.
- **RETIRE:** compute the new PC, then go to IDLE.
  - Default: PC+1.
  - ISZ with result 0: PC+2.
  - JMP: `base_addr`.
  - JMS: `base_addr`+1.
  - Group 2 skip taken: PC+2.
- **Group 1 order:** CLA/CLL, then CMA/CML, then IAC (carry into L), then rotate. RAR/RAL rotate {L,AC} by 1, RTR/RTL by 2, BSW swaps 6-bit halves.
- **Group 2:**
  - SMA|SZA|SNL: skip if any selected condition is true.
  - SPA|SNA|SZL: skip if all selected conditions are true.
  - CLA is applied after the test.
  - HLT goes to HALTED.
  - OSR is executed as NOP (no switch register).
- **Width rules:** all PC arithmetic is mod 2^12; 7777+1 wraps to 0000.

## Timing
- **Reset values:** `stall`=0, `PC_value`=`START_ADDR`, AC=0, L=0, all request strobes 0, addresses and write data 0, state IDLE.
- **`stall`:** rises the cycle after accept and falls on the cycle following RETIRE. `PC_value` changes only in that same cycle.
- **Latency, accept to `stall` low:**
  - JMP/op7: 2 cycles.
  - DCA/JMS: 3 cycles.
  - AND/TAD: 4 cycles.
  - ISZ: 5 cycles.
- Read and write strobes never coincide.
- **Input stability:** inputs may change while `stall`=1; they are ignored until IDLE.
- **HALTED:** `stall` held at 1 and no memory strobes until `reset_n` is asserted.
- **Reset mid-operation:** any in-flight write strobe is dropped immediately; the memory word is not guaranteed.

## Structure
- **Package `pdp_pkg`:** `pdp_mem_opcode_s`, `pdp_op7_opcode_s`, the `ADDR_WIDTH`/`DATA_WIDTH` values, the `START_ADDR` default and the state enum.
- **Sub-module `op7_unit`:** combinational. Takes {L,AC} and `pdp_op7_opcode`; returns new {L,AC}, skip and halt. It is instantiated once.

## Test plan
- Reset, then JMP with `base_addr`=0o300 → `stall` high for 2 cycles, then `PC_value`=0o300, no memory strobes.
- TAD with AC=7777, L=0 at 0o200, memory[0o050]=0001 → read at 0o050, then AC=0000, L=1, `PC_value`=0o201.
- ISZ with memory[0o060]=7777 → write 0000 to 0o060, `PC_value`=PC+2; with memory=0005 → write 0006, PC+1.
- JMS with `base_addr`=0o400 at PC=0o210 → write 0o211 to 0o400, then `PC_value`=0o401.
- OPR group 1 with CLA CLL CMA IAC → {L,AC} = 1,0000; group 2 with SZA when AC=0 → PC+2.
- HLT → `stall` stays at 1 for 100 cycles. Asserting `reset_n` mid-ISZ WRITE → outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pdp_pkg.sv
// Shared types and constants for the PDP-8 pipeline: opcode flag bundles,
// datapath widths and the execute-stage state encoding.
package pdp_pkg;
    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;
    localparam logic [ADDR_WIDTH-1:0] START_ADDR_DEFAULT = 12'o200;

    typedef struct packed {
        logic AND;
        logic TAD;
        logic ISZ;
        logic DCA;
        logic JMS;
        logic JMP;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic CLA;
        logic CLL;
        logic CMA;
        logic CML;
        logic IAC;
        logic RAR;
        logic RAL;
        logic RTR;
        logic RTL;
        logic BSW;
        logic SMA;
        logic SZA;
        logic SNL;
        logic SPA;
        logic SNA;
        logic SZL;
        logic HLT;
        logic OSR;
        logic NOP;
    } pdp_op7_opcode_s;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RETIRE,
        HALTED
    } exec_state_e;
endpackage

// File: rtl/op7_unit.sv
// Combinational OPR microinstruction evaluator: applies group 1 operations to
// {L,AC} and evaluates the group 2 skip condition against the incoming {L,AC}.
module op7_unit
    import pdp_pkg::*;
(
    input  logic                  link_in,
    input  logic [DATA_WIDTH-1:0] ac_in,
    input  pdp_op7_opcode_s       op7,
    output logic                  link_out,
    output logic [DATA_WIDTH-1:0] ac_out,
    output logic                  skip,
    output logic                  halt
);
    logic [DATA_WIDTH:0] la;
    logic [DATA_WIDTH:0] inc;
    logic                or_sel;
    logic                and_sel;
    logic                ac_zero;
    logic                unused_flags;

    assign unused_flags = op7.OSR | op7.NOP;
    assign halt         = op7.HLT;
    assign ac_zero      = (ac_in == '0);
    assign or_sel       = op7.SMA | op7.SZA | op7.SNL;
    assign and_sel      = op7.SPA | op7.SNA | op7.SZL;

    always_comb begin
        la  = {link_in, ac_in};
        inc = '0;
        if (op7.CLA) la[DATA_WIDTH-1:0] = '0;
        if (op7.CLL) la[DATA_WIDTH] = 1'b0;
        if (op7.CMA) la[DATA_WIDTH-1:0] = ~la[DATA_WIDTH-1:0];
        if (op7.CML) la[DATA_WIDTH] = ~la[DATA_WIDTH];
        if (op7.IAC) begin
            inc = {1'b0, la[DATA_WIDTH-1:0]} + 13'd1;
            la  = {la[DATA_WIDTH] ^ inc[DATA_WIDTH], inc[DATA_WIDTH-1:0]};
        end
        // Rotates act on the 13-bit {L,AC}; BSW swaps the 6-bit halves of AC only.
        if (op7.RTR)      la = {la[1:0], la[DATA_WIDTH:2]};
        else if (op7.RAR) la = {la[0], la[DATA_WIDTH:1]};
        else if (op7.RTL) la = {la[DATA_WIDTH-2:0], la[DATA_WIDTH:DATA_WIDTH-1]};
        else if (op7.RAL) la = {la[DATA_WIDTH-1:0], la[DATA_WIDTH]};
        else if (op7.BSW) la = {la[DATA_WIDTH], la[5:0], la[11:6]};
        link_out = la[DATA_WIDTH];
        ac_out   = la[DATA_WIDTH-1:0];
    end

    always_comb begin
        skip = 1'b0;
        if (or_sel)
            skip = (op7.SMA & ac_in[DATA_WIDTH-1]) | (op7.SZA & ac_zero) | (op7.SNL & link_in);
        else if (and_sel)
            skip = (~op7.SPA | ~ac_in[DATA_WIDTH-1]) & (~op7.SNA | ~ac_zero) & (~op7.SZL | ~link_in);
    end
endmodule

// File: rtl/instr_exec.sv
// PDP-8 execute stage: runs memory read/modify/write for memory-reference
// instructions, evaluates OPR microinstructions and returns the next PC.
module instr_exec
    import pdp_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = START_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  pdp_mem_opcode_s       pdp_mem_opcode,
    input  pdp_op7_opcode_s       pdp_op7_opcode,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  exec_rd_req,
    output logic [ADDR_WIDTH-1:0] exec_rd_addr,
    input  logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_wr_req,
    output logic [ADDR_WIDTH-1:0] exec_wr_addr,
    output logic [DATA_WIDTH-1:0] exec_wr_data
);
    exec_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    pdp_mem_opcode_s       mem_op_q, mem_op_d;
    pdp_op7_opcode_s       op7_q, op7_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic                  link_q, link_d;
    logic [DATA_WIDTH-1:0] mb_q, mb_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  stall_q, stall_d;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  wr_req_q, wr_req_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [DATA_WIDTH-1:0] op7_ac;
    logic                  op7_link;
    logic                  op7_skip;
    logic                  op7_halt;
    logic [DATA_WIDTH:0]   tad_sum;
    logic [DATA_WIDTH-1:0] mb_inc;

    op7_unit u_op7 (
        .link_in  (link_q),
        .ac_in    (ac_q),
        .op7      (op7_q),
        .link_out (op7_link),
        .ac_out   (op7_ac),
        .skip     (op7_skip),
        .halt     (op7_halt)
    );

    assign tad_sum = {1'b0, ac_q} + {1'b0, exec_rd_data};
    assign mb_inc  = exec_rd_data + 12'd1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mem_op_d  = mem_op_q;
        op7_d     = op7_q;
        ac_d      = ac_q;
        link_d    = link_q;
        mb_d      = mb_q;
        pc_d      = pc_q;
        stall_d   = stall_q;
        rd_req_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_req_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if ((|pdp_mem_opcode) || (|pdp_op7_opcode)) begin
                    addr_d   = base_addr;
                    mem_op_d = pdp_mem_opcode;
                    op7_d    = pdp_op7_opcode;
                    stall_d  = 1'b1;
                    if (pdp_mem_opcode.AND || pdp_mem_opcode.TAD || pdp_mem_opcode.ISZ) begin
                        state_d   = READ;
                        rd_req_d  = 1'b1;
                        rd_addr_d = base_addr;
                    end else if (pdp_mem_opcode.DCA || pdp_mem_opcode.JMS) begin
                        state_d   = WRITE;
                        wr_req_d  = 1'b1;
                        wr_addr_d = base_addr;
                        wr_data_d = pdp_mem_opcode.DCA ? ac_q : pc_q + 12'd1;
                    end else begin
                        state_d = RETIRE;
                    end
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                mb_d    = exec_rd_data;
                state_d = RETIRE;
                if (mem_op_q.AND) ac_d = ac_q & exec_rd_data;
                if (mem_op_q.TAD) begin
                    ac_d   = tad_sum[DATA_WIDTH-1:0];
                    link_d = link_q ^ tad_sum[DATA_WIDTH];
                end
                if (mem_op_q.ISZ) begin
                    mb_d      = mb_inc;
                    state_d   = WRITE;
                    wr_req_d  = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = mb_inc;
                end
            end
            WRITE: begin
                if (mem_op_q.DCA) ac_d = '0;
                state_d = RETIRE;
            end
            RETIRE: begin
                state_d = IDLE;
                stall_d = 1'b0;
                pc_d    = pc_q + 12'd1;
                if (mem_op_q.ISZ && mb_q == '0) pc_d = pc_q + 12'd2;
                if (mem_op_q.JMP) pc_d = addr_q;
                if (mem_op_q.JMS) pc_d = addr_q + 12'd1;
                // An OPR instruction is one that arrived with no memory opcode.
                if (!(|mem_op_q)) begin
                    ac_d   = op7_ac;
                    link_d = op7_link;
                    if (op7_halt) begin
                        state_d = HALTED;
                        stall_d = 1'b1;
                        pc_d    = pc_q;
                    end else if (op7_skip) begin
                        pc_d = pc_q + 12'd2;
                    end
                end
            end
            HALTED: stall_d = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mem_op_q  <= '0;
            op7_q     <= '0;
            ac_q      <= '0;
            link_q    <= 1'b0;
            mb_q      <= '0;
            pc_q      <= START_ADDR;
            stall_q   <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mem_op_q  <= mem_op_d;
            op7_q     <= op7_d;
            ac_q      <= ac_d;
            link_q    <= link_d;
            mb_q      <= mb_d;
            pc_q      <= pc_d;
            stall_q   <= stall_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign stall        = stall_q;
    assign PC_value     = pc_q;
    assign exec_rd_req  = rd_req_q;
    assign exec_rd_addr = rd_addr_q;
    assign exec_wr_req  = wr_req_q;
    assign exec_wr_addr = wr_addr_q;
    assign exec_wr_data = wr_data_q;
endmodule

// File: tb/tb_instr_exec.sv
// Directed-vector bench for instr_exec with a small behavioural data memory.
module tb_instr_exec;
    import pdp_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [11:0]     base_addr;
    pdp_mem_opcode_s pdp_mem_opcode;
    pdp_op7_opcode_s pdp_op7_opcode;
    logic            stall;
    logic [11:0]     PC_value;
    logic            exec_rd_req;
    logic [11:0]     exec_rd_addr;
    logic [11:0]     exec_rd_data = '0;
    logic            exec_wr_req;
    logic [11:0]     exec_wr_addr;
    logic [11:0]     exec_wr_data;

    logic [11:0] mem [0:4095];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap_cnt = 0;
    logic [11:0] last_rd_addr = '0;
    logic [11:0] last_wr_addr = '0;
    logic [11:0] last_wr_data = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    instr_exec #(.START_ADDR(12'o200)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .base_addr      (base_addr),
        .pdp_mem_opcode (pdp_mem_opcode),
        .pdp_op7_opcode (pdp_op7_opcode),
        .stall          (stall),
        .PC_value       (PC_value),
        .exec_rd_req    (exec_rd_req),
        .exec_rd_addr   (exec_rd_addr),
        .exec_rd_data   (exec_rd_data),
        .exec_wr_req    (exec_wr_req),
        .exec_wr_addr   (exec_wr_addr),
        .exec_wr_data   (exec_wr_data)
    );

    always @(posedge clk) begin
        if (exec_rd_req) begin
            exec_rd_data <= mem[exec_rd_addr];
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= exec_rd_addr;
        end
        if (exec_wr_req) begin
            mem[exec_wr_addr] = exec_wr_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= exec_wr_addr;
            last_wr_data <= exec_wr_data;
        end
        if (exec_rd_req && exec_wr_req) overlap_cnt <= overlap_cnt + 1;
    end

    // Present one instruction, hold junk on the inputs while stalled, and
    // report cycles from accept to stall low plus strobe counts.
    task automatic issue(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o, input logic [11:0] a,
                         output int lat, output int rd_d, output int wr_d);
        int rd0;
        int wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        pdp_mem_opcode = m;
        pdp_op7_opcode = o;
        base_addr      = a;
        @(posedge clk); #1;
        pdp_mem_opcode     = '0;
        pdp_mem_opcode.JMP = 1'b1;
        pdp_op7_opcode     = '0;
        base_addr          = 12'o7777;
        lat = 1;
        while (stall === 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        pdp_mem_opcode = '0;
        pdp_op7_opcode = '0;
        base_addr      = '0;
        rd_d = rd_cnt - rd0;
        wr_d = wr_cnt - wr0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pdp_mem_opcode = '0;
        pdp_op7_opcode = '0;
        base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (PC_value !== 12'o200) begin errors++; $display("FAIL reset_pc got %o want 200", PC_value); end
        checks++; if ({exec_rd_req, exec_wr_req} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {exec_rd_req, exec_wr_req}); end
        checks++; if ({exec_rd_addr, exec_wr_addr, exec_wr_data} !== 36'd0) begin errors++; $display("FAIL reset_addr_data got %o/%o/%o want 0/0/0", exec_rd_addr, exec_wr_addr, exec_wr_data); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_jmp();
        pdp_mem_opcode_s m;
        int lat, rd_d, wr_d;
        m = '0; m.JMP = 1'b1;
        issue(m, '0, 12'o300, lat, rd_d, wr_d);
        checks++; if (lat !== 2) begin errors++; $display("FAIL jmp_latency got %0d want 2", lat); end
        checks++; if (PC_value !== 12'o300) begin errors++; $display("FAIL jmp_pc got %o want 300", PC_value); end
        checks++; if (rd_d !== 0 || wr_d !== 0) begin errors++; $display("FAIL jmp_strobes got rd %0d wr %0d want 0 0", rd_d, wr_d); end
        issue(m, '0, 12'o177, lat, rd_d, wr_d);
        checks++; if (PC_value !== 12'o177) begin errors++; $display("FAIL jmp2_pc got %o want 177", PC_value); end
    endtask

    task automatic test_tad();
        pdp_mem_opcode_s m;
        pdp_op7_opcode_s o;
        int lat, rd_d, wr_d;
        o = '0; o.CMA = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        checks++; if (PC_value !== 12'o200) begin errors++; $display("FAIL cma_pc got %o want 200", PC_value); end
        mem[12'o050] = 12'o0001;
        m = '0; m.TAD = 1'b1;
        issue(m, '0, 12'o050, lat, rd_d, wr_d);
        checks++; if (lat !== 4) begin errors++; $display("FAIL tad_latency got %0d want 4", lat); end
        checks++; if (rd_d !== 1 || wr_d !== 0 || last_rd_addr !== 12'o050) begin errors++; $display("FAIL tad_read got rd %0d wr %0d addr %o want 1 0 050", rd_d, wr_d, last_rd_addr); end
        checks++; if (PC_value !== 12'o201) begin errors++; $display("FAIL tad_pc got %o want 201", PC_value); end
        m = '0; m.DCA = 1'b1;
        issue(m, '0, 12'o070, lat, rd_d, wr_d);
        checks++; if (lat !== 3) begin errors++; $display("FAIL dca_latency got %0d want 3", lat); end
        checks++; if (wr_d !== 1 || rd_d !== 0 || last_wr_addr !== 12'o070 || last_wr_data !== 12'o0000) begin errors++; $display("FAIL tad_ac got wr %0d addr %o data %o want 1 070 0000", wr_d, last_wr_addr, last_wr_data); end
        checks++; if (PC_value !== 12'o202) begin errors++; $display("FAIL dca_pc got %o want 202", PC_value); end
        o = '0; o.SNL = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        checks++; if (PC_value !== 12'o204) begin errors++; $display("FAIL tad_link got pc %o want 204", PC_value); end
    endtask

    task automatic test_and();
        pdp_mem_opcode_s m;
        int lat, rd_d, wr_d;
        mem[12'o051] = 12'o1234;
        mem[12'o052] = 12'o0770;
        m = '0; m.TAD = 1'b1;
        issue(m, '0, 12'o051, lat, rd_d, wr_d);
        m = '0; m.AND = 1'b1;
        issue(m, '0, 12'o052, lat, rd_d, wr_d);
        checks++; if (lat !== 4) begin errors++; $display("FAIL and_latency got %0d want 4", lat); end
        checks++; if (PC_value !== 12'o206) begin errors++; $display("FAIL and_pc got %o want 206", PC_value); end
        m = '0; m.DCA = 1'b1;
        issue(m, '0, 12'o071, lat, rd_d, wr_d);
        checks++; if (last_wr_data !== 12'o0230 || mem[12'o071] !== 12'o0230) begin errors++; $display("FAIL and_ac got %o want 0230", last_wr_data); end
    endtask

    task automatic test_isz();
        pdp_mem_opcode_s m;
        int lat, rd_d, wr_d;
        mem[12'o060] = 12'o7777;
        mem[12'o061] = 12'o0005;
        m = '0; m.ISZ = 1'b1;
        issue(m, '0, 12'o060, lat, rd_d, wr_d);
        checks++; if (lat !== 5) begin errors++; $display("FAIL isz_latency got %0d want 5", lat); end
        checks++; if (rd_d !== 1 || wr_d !== 1 || last_wr_addr !== 12'o060 || last_wr_data !== 12'o0000) begin errors++; $display("FAIL isz_wrap_write got rd %0d wr %0d addr %o data %o want 1 1 060 0000", rd_d, wr_d, last_wr_addr, last_wr_data); end
        checks++; if (PC_value !== 12'o211) begin errors++; $display("FAIL isz_skip_pc got %o want 211", PC_value); end
        issue(m, '0, 12'o061, lat, rd_d, wr_d);
        checks++; if (last_wr_addr !== 12'o061 || last_wr_data !== 12'o0006) begin errors++; $display("FAIL isz_write got addr %o data %o want 061 0006", last_wr_addr, last_wr_data); end
        checks++; if (PC_value !== 12'o212) begin errors++; $display("FAIL isz_noskip_pc got %o want 212", PC_value); end
    endtask

    task automatic test_jms();
        pdp_mem_opcode_s m;
        int lat, rd_d, wr_d;
        m = '0; m.JMP = 1'b1;
        issue(m, '0, 12'o210, lat, rd_d, wr_d);
        m = '0; m.JMS = 1'b1;
        issue(m, '0, 12'o400, lat, rd_d, wr_d);
        checks++; if (lat !== 3) begin errors++; $display("FAIL jms_latency got %0d want 3", lat); end
        checks++; if (wr_d !== 1 || last_wr_addr !== 12'o400 || last_wr_data !== 12'o0211) begin errors++; $display("FAIL jms_write got wr %0d addr %o data %o want 1 400 0211", wr_d, last_wr_addr, last_wr_data); end
        checks++; if (PC_value !== 12'o401) begin errors++; $display("FAIL jms_pc got %o want 401", PC_value); end
    endtask

    task automatic test_op7();
        pdp_mem_opcode_s dca;
        pdp_op7_opcode_s o;
        int lat, rd_d, wr_d;
        dca = '0; dca.DCA = 1'b1;
        o = '0; o.CLA = 1'b1; o.CLL = 1'b1; o.CMA = 1'b1; o.IAC = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        checks++; if (lat !== 2 || PC_value !== 12'o402) begin errors++; $display("FAIL grp1_pc got lat %0d pc %o want 2 402", lat, PC_value); end
        o = '0; o.SZA = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        checks++; if (PC_value !== 12'o404) begin errors++; $display("FAIL sza_skip got pc %o want 404", PC_value); end
        o = '0; o.SNL = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        checks++; if (PC_value !== 12'o406) begin errors++; $display("FAIL iac_carry got pc %o want 406", PC_value); end
        o = '0; o.CLA = 1'b1; o.CLL = 1'b1; o.CMA = 1'b1; o.RAL = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        issue(dca, '0, 12'o072, lat, rd_d, wr_d);
        checks++; if (last_wr_data !== 12'o7776) begin errors++; $display("FAIL ral_ac got %o want 7776", last_wr_data); end
        o = '0; o.SZL = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        checks++; if (PC_value !== 12'o411) begin errors++; $display("FAIL ral_link got pc %o want 411", PC_value); end
        o = '0; o.CLA = 1'b1; o.CLL = 1'b1; o.IAC = 1'b1; o.BSW = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        issue(dca, '0, 12'o073, lat, rd_d, wr_d);
        checks++; if (last_wr_data !== 12'o0100) begin errors++; $display("FAIL bsw_ac got %o want 0100", last_wr_data); end
        o = '0; o.CLA = 1'b1; o.CLL = 1'b1; o.CMA = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        o = '0; o.SZA = 1'b1; o.CLA = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        checks++; if (PC_value !== 12'o415) begin errors++; $display("FAIL sza_cla_pc got %o want 415", PC_value); end
        issue(dca, '0, 12'o074, lat, rd_d, wr_d);
        checks++; if (last_wr_data !== 12'o0000) begin errors++; $display("FAIL sza_cla_ac got %o want 0000", last_wr_data); end
        o = '0; o.CLA = 1'b1; o.CLL = 1'b1; o.IAC = 1'b1; o.RTR = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        issue(dca, '0, 12'o075, lat, rd_d, wr_d);
        checks++; if (last_wr_data !== 12'o4000 || PC_value !== 12'o420) begin errors++; $display("FAIL rtr_ac got %o pc %o want 4000 420", last_wr_data, PC_value); end
    endtask

    task automatic test_pc_wrap();
        pdp_mem_opcode_s m;
        pdp_op7_opcode_s o;
        int lat, rd_d, wr_d;
        m = '0; m.JMP = 1'b1;
        issue(m, '0, 12'o7777, lat, rd_d, wr_d);
        o = '0; o.NOP = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        checks++; if (PC_value !== 12'o0000) begin errors++; $display("FAIL wrap_inc got %o want 0000", PC_value); end
        issue(m, '0, 12'o7776, lat, rd_d, wr_d);
        o = '0; o.SZA = 1'b1;
        issue('0, o, '0, lat, rd_d, wr_d);
        checks++; if (PC_value !== 12'o0000) begin errors++; $display("FAIL wrap_skip got %o want 0000", PC_value); end
    endtask

    task automatic test_hlt();
        int bad;
        int rd0;
        int wr0;
        bad = 0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        pdp_op7_opcode = '0;
        pdp_op7_opcode.HLT = 1'b1;
        @(posedge clk); #1;
        pdp_op7_opcode = '0;
        pdp_mem_opcode = '0;
        pdp_mem_opcode.TAD = 1'b1;
        base_addr = 12'o050;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (stall !== 1'b1) bad++;
        end
        pdp_mem_opcode = '0;
        base_addr = '0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL hlt_stall got %0d low cycles want 0", bad); end
        checks++; if (rd_cnt !== rd0 || wr_cnt !== wr0) begin errors++; $display("FAIL hlt_strobes got rd %0d wr %0d want 0 0", rd_cnt - rd0, wr_cnt - wr0); end
        checks++; if (PC_value !== 12'o0000) begin errors++; $display("FAIL hlt_pc got %o want 0000", PC_value); end
    endtask

    task automatic test_reset_mid_isz();
        int n;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        mem[12'o062] = 12'o0010;
        pdp_mem_opcode = '0;
        pdp_mem_opcode.ISZ = 1'b1;
        base_addr = 12'o062;
        @(posedge clk); #1;
        pdp_mem_opcode = '0;
        base_addr = '0;
        n = 0;
        while (exec_wr_req !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (exec_wr_req !== 1'b1) begin errors++; $display("FAIL isz_reach_write got %b want 1", exec_wr_req); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (exec_wr_req !== 1'b0 || exec_rd_req !== 1'b0) begin errors++; $display("FAIL async_strobes got rd %b wr %b want 0 0", exec_rd_req, exec_wr_req); end
        checks++; if (stall !== 1'b0 || PC_value !== 12'o200) begin errors++; $display("FAIL async_state got stall %b pc %o want 0 200", stall, PC_value); end
        checks++; if (exec_wr_addr !== 12'o0 || exec_wr_data !== 12'o0) begin errors++; $display("FAIL async_wr_bus got %o/%o want 0/0", exec_wr_addr, exec_wr_data); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_tad();
        test_and();
        test_isz();
        test_jms();
        test_op7();
        test_pc_wrap();
        test_hlt();
        test_reset_mid_isz();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", overlap_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
